dmem_arbiter: RTL and testbench

//   Shares the single-port, word-wide data RAM between two requesters:

---
 rtl/dmem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data RAM.
// Port 0 is the pipeline MEM stage and port 1 is the DMA/loader.
// The RAM has no byte enables, so a partial store becomes a read-modify-write:
// the old word is read in IDLE and the merged word is written in RMW_WR.
//
// state  | meaning
// IDLE   | accepts at most one request per cycle
// RMW_WR | writes the merged word for a partial store; no grants this cycle
module dmem_arbiter #(
    parameter bit          RR_EN     = 1'b1,
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        p0_valid_i,
    output logic        p0_ready_o,
    input  logic        p0_we_i,
    input  logic [31:0] p0_addr_i,
    input  logic [31:0] p0_wdata_i,
    input  logic [3:0]  p0_be_i,
    output logic        p0_rvalid_o,
    output logic [31:0] p0_rdata_o,
    input  logic        p1_valid_i,
    output logic        p1_ready_o,
    input  logic        p1_we_i,
    input  logic [31:0] p1_addr_i,
    input  logic [31:0] p1_wdata_i,
    input  logic [3:0]  p1_be_i,
    output logic        p1_rvalid_o,
    output logic [31:0] p1_rdata_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic {IDLE, RMW_WR} state_e;

    state_e             state_q;
    logic               last_grant_q;
    logic               rmw_port_q;
    logic [IDX_W-1:0]   rmw_idx_q;
    logic [31:0]        rmw_old_q;
    logic [31:0]        rmw_wdata_q;
    logic [3:0]         rmw_be_q;
    logic               p0_rvalid_q;
    logic               p1_rvalid_q;
    logic [31:0]        p0_rdata_q;
    logic [31:0]        p1_rdata_q;

    logic               grant_ok;
    logic               grant0;
    logic               grant1;
    logic               accept;
    logic               sel_we;
    logic [31:0]        sel_addr;
    logic [31:0]        sel_wdata;
    logic [3:0]         sel_be;
    logic               sel_full;
    logic               sel_partial;
    logic [31:0]        merge_d;

    // Port 1 wins a contention only in round-robin mode when port 0 had the last grant.
    assign grant_ok    = (state_q == IDLE) && !rst_i;
    assign grant1      = grant_ok && p1_valid_i && (!p0_valid_i || (RR_EN && !last_grant_q));
    assign grant0      = grant_ok && p0_valid_i && !grant1;
    assign accept      = grant0 || grant1;
    assign p0_ready_o  = grant0;
    assign p1_ready_o  = grant1;

    assign sel_we      = grant1 ? p1_we_i    : p0_we_i;
    assign sel_addr    = grant1 ? p1_addr_i  : p0_addr_i;
    assign sel_wdata   = grant1 ? p1_wdata_i : p0_wdata_i;
    assign sel_be      = grant1 ? p1_be_i    : p0_be_i;
    assign sel_full    = (sel_be == 4'hF);
    assign sel_partial = (sel_be != 4'h0) && !sel_full;

    assign p0_rvalid_o = p0_rvalid_q;
    assign p1_rvalid_o = p1_rvalid_q;
    assign p0_rdata_o  = p0_rdata_q;
    assign p1_rdata_o  = p1_rdata_q;

    // Byte-lane merge of the saved store data over the saved old word.
    always_comb begin
        merge_d = rmw_old_q;
        for (int i = 0; i < 4; i++) begin
            if (rmw_be_q[i]) begin
                merge_d[8*i +: 8] = rmw_wdata_q[8*i +: 8];
            end
        end
    end

    // RAM drive: RMW write-back, else the granted request, else all zero.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (!rst_i && state_q == RMW_WR) begin
            mem_we_o                = 1'b1;
            mem_addr_o[IDX_W+1:2]   = rmw_idx_q;
            mem_wdata_o             = merge_d;
        end else if (accept) begin
            mem_addr_o = sel_addr;
            if (sel_we && sel_full) begin
                mem_we_o    = 1'b1;
                mem_wdata_o = sel_wdata;
            end
        end
    end

    // Arbiter FSM with registered responses; stores return the pre-write word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            rmw_port_q   <= 1'b0;
            rmw_idx_q    <= '0;
            rmw_old_q    <= '0;
            rmw_wdata_q  <= '0;
            rmw_be_q     <= '0;
            p0_rvalid_q  <= 1'b0;
            p1_rvalid_q  <= 1'b0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
        end else begin
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        last_grant_q <= grant1;
                        if (sel_we && sel_partial) begin
                            rmw_port_q  <= grant1;
                            rmw_idx_q   <= sel_addr[IDX_W+1:2];
                            rmw_old_q   <= mem_rdata_i;
                            rmw_wdata_q <= sel_wdata;
                            rmw_be_q    <= sel_be;
                            state_q     <= RMW_WR;
                        end else if (grant1) begin
                            p1_rvalid_q <= 1'b1;
                            p1_rdata_q  <= mem_rdata_i;
                        end else begin
                            p0_rvalid_q <= 1'b1;
                            p0_rdata_q  <= mem_rdata_i;
                        end
                    end
                end
                RMW_WR: begin
                    if (rmw_port_q) begin
                        p1_rvalid_q <= 1'b1;
                        p1_rdata_q  <= rmw_old_q;
                    end else begin
                        p0_rvalid_q <= 1'b1;
                        p0_rdata_q  <= rmw_old_q;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin instance (k=0) and a fixed-priority
// instance (k=1) see the same stimulus, each with its own RAM. A request-level
// model predicts grants, RAM traffic and responses; a monitor scores responses.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_valid, p0_we, p1_valid, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [3:0]  p0_be, p1_be;
    logic        pre_we;
    logic [31:0] pre_addr, pre_data;

    logic [1:0]  p0_ready, p1_ready, p0_rvalid, p1_rvalid, mem_we;
    logic [31:0] p0_rdata [2];
    logic [31:0] p1_rdata [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];

    int n_chk  = 0;
    int n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        logic [31:0] ram [256];

        dmem_arbiter #(.RR_EN(g == 0), .MEM_WORDS(256)) dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .p0_valid_i  (p0_valid),
            .p0_ready_o  (p0_ready[g]),
            .p0_we_i     (p0_we),
            .p0_addr_i   (p0_addr),
            .p0_wdata_i  (p0_wdata),
            .p0_be_i     (p0_be),
            .p0_rvalid_o (p0_rvalid[g]),
            .p0_rdata_o  (p0_rdata[g]),
            .p1_valid_i  (p1_valid),
            .p1_ready_o  (p1_ready[g]),
            .p1_we_i     (p1_we),
            .p1_addr_i   (p1_addr),
            .p1_wdata_i  (p1_wdata),
            .p1_be_i     (p1_be),
            .p1_rvalid_o (p1_rvalid[g]),
            .p1_rdata_o  (p1_rdata[g]),
            .mem_we_o    (mem_we[g]),
            .mem_addr_o  (mem_addr[g]),
            .mem_wdata_o (mem_wdata[g]),
            .mem_rdata_i (mem_rdata[g])
        );

        always @(posedge clk) begin
            if (pre_we) ram[pre_addr[9:2]] <= pre_data;
            else if (mem_we[g]) ram[mem_addr[g][9:2]] <= mem_wdata[g];
        end
        assign mem_rdata[g] = ram[mem_addr[g][9:2]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] mask = 32'h0;
        for (int i = 0; i < 4; i++) if (be[i]) mask |= 32'hFF << (8 * i);
        return (old & ~mask) | (wd & mask);
    endfunction

    // Reference state: words, last winner, pending partial store, expected responses.
    logic [31:0] mm [2][256];
    bit          lg [2];
    bit          busy [2];
    bit          pend_port [2];
    logic [7:0]  pend_idx [2];
    logic [31:0] pend_old [2];
    logic [31:0] exp_q [4][$];

    always @(negedge clk) begin : model
        logic [1:0]  e_r;
        logic        e_we;
        logic [31:0] e_addr, e_wd, a, wd, old;
        logic [3:0]  be;
        logic        we;
        int          win;
        if (pre_we) begin
            mm[0][pre_addr[9:2]] = pre_data;
            mm[1][pre_addr[9:2]] = pre_data;
        end
        for (int k = 0; k < 2; k++) begin
            e_r = 2'b00; e_we = 1'b0; e_addr = 32'h0; e_wd = 32'h0;
            if (rst) begin
                if (busy[k]) begin
                    mm[k][pend_idx[k]] = pend_old[k];
                    void'(exp_q[k*2 + int'(pend_port[k])].pop_back());
                end
                busy[k] = 1'b0;
                lg[k]   = 1'b1;
            end else if (busy[k]) begin
                e_we   = 1'b1;
                e_addr = {22'h0, pend_idx[k], 2'b00};
                e_wd   = mm[k][pend_idx[k]];
                busy[k] = 1'b0;
            end else begin
                win = -1;
                if (p0_valid && p1_valid) win = (k == 0 && lg[k]) ? 0 : ((k == 0) ? 1 : 0);
                else if (p0_valid) win = 0;
                else if (p1_valid) win = 1;
                if (win >= 0) begin
                    e_r[win] = 1'b1;
                    a   = (win == 1) ? p1_addr  : p0_addr;
                    wd  = (win == 1) ? p1_wdata : p0_wdata;
                    be  = (win == 1) ? p1_be    : p0_be;
                    we  = (win == 1) ? p1_we    : p0_we;
                    old = mm[k][a[9:2]];
                    exp_q[k*2 + win].push_back(old);
                    lg[k]  = (win == 1);
                    e_addr = a;
                    if (we && be == 4'hF) begin
                        e_we = 1'b1;
                        e_wd = wd;
                        mm[k][a[9:2]] = wd;
                    end else if (we && be != 4'h0) begin
                        mm[k][a[9:2]] = merge(old, wd, be);
                        busy[k]      = 1'b1;
                        pend_port[k] = (win == 1);
                        pend_idx[k]  = a[9:2];
                        pend_old[k]  = old;
                    end
                end
            end
            chk($sformatf("k%0d p0_ready", k), 32'(p0_ready[k]), 32'(e_r[0]));
            chk($sformatf("k%0d p1_ready", k), 32'(p1_ready[k]), 32'(e_r[1]));
            chk($sformatf("k%0d mem_we", k), 32'(mem_we[k]), 32'(e_we));
            chk($sformatf("k%0d mem_addr", k), mem_addr[k], e_addr);
            chk($sformatf("k%0d mem_wdata", k), mem_wdata[k], e_wd);
        end
    end

    // Response monitor: every rvalid pulse must match the oldest expected word for that port.
    always @(negedge clk) begin : monitor
        logic        rv;
        logic [31:0] rd;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                rv = (p == 1) ? p1_rvalid[k] : p0_rvalid[k];
                rd = (p == 1) ? p1_rdata[k]  : p0_rdata[k];
                if (rv) begin
                    if (exp_q[k*2 + p].size() == 0)
                        chk($sformatf("k%0d p%0d unexpected rvalid", k, p), 32'(rv), 32'h0);
                    else
                        chk($sformatf("k%0d p%0d rdata", k, p), rd, exp_q[k*2 + p].pop_front());
                end
            end
        end
    end

    task automatic drive(input logic r,
                         input logic v0, input logic we0, input logic [31:0] a0,
                         input logic [31:0] wd0, input logic [3:0] be0,
                         input logic v1, input logic we1, input logic [31:0] a1,
                         input logic [31:0] wd1, input logic [3:0] be1);
        rst = r;
        p0_valid = v0; p0_we = we0; p0_addr = a0; p0_wdata = wd0; p0_be = be0;
        p1_valid = v1; p1_we = we1; p1_addr = a1; p1_wdata = wd1; p1_be = be1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; pre_we = 1'b0; pre_addr = 32'h0; pre_data = 32'h0;
        p0_valid = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_be = 0;
        p1_valid = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_be = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i <= 16; i++) begin
            pre_we   = 1'b1;
            pre_addr = i * 4;
            pre_data = (i == 8) ? 32'h11223344 : (i == 16) ? 32'h00000055 : $urandom();
            @(posedge clk);
            #1;
        end
        pre_we = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("k%0d reset p0_rvalid", k), 32'(p0_rvalid[k]), 32'h0);
            chk($sformatf("k%0d reset p1_rvalid", k), 32'(p1_rvalid[k]), 32'h0);
            chk($sformatf("k%0d reset p0_rdata", k), p0_rdata[k], 32'h0);
            chk($sformatf("k%0d reset p1_rdata", k), p1_rdata[k], 32'h0);
        end
        @(posedge clk);
        #1;

        // full store then load back
        drive(0, 1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 0, 0);
        idle(2);
        // partial store from port 1, reload held through the RMW cycle
        drive(0, 0, 0, 0, 0, 0, 1, 1, 32'h20, 32'h0000AA00, 4'b0010);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 32'h20, 32'h0, 4'h0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 32'h20, 32'h0, 4'h0);
        idle(2);
        // sustained contention
        for (int i = 0; i < 4; i++)
            drive(0, 1, 0, 32'h04 * i, 0, 0, 1, 0, 32'h20 + 32'h4 * i, 0, 0);
        idle(2);
        // port 0 partial store, port 1 load of the same word stalls behind it
        drive(0, 1, 1, 32'h24, 32'h77000000, 4'b1000, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 32'h24, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 32'h24, 0, 0);
        idle(2);
        // reset during the write-back cycle
        drive(0, 1, 1, 32'h30, 32'h00CC0000, 4'b0100, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 32'h30, 0, 0, 1, 0, 32'h10, 0, 0);
        drive(0, 1, 0, 32'h30, 0, 0, 1, 0, 32'h10, 0, 0);
        idle(2);
        // store with no byte enables
        drive(0, 1, 1, 32'h40, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // randomized traffic over a small word pool
        for (int i = 0; i < 600; i++) begin
            logic        r, v0, v1, w0, w1;
            logic [31:0] a0, a1, d0, d1;
            logic [3:0]  b0, b1;
            int          s;
            r  = ($urandom_range(0, 63) == 0);
            v0 = ($urandom_range(0, 9) < 7);
            v1 = ($urandom_range(0, 9) < 7);
            w0 = 1'($urandom_range(0, 1));
            w1 = 1'($urandom_range(0, 1));
            a0 = 32'($urandom_range(0, 16)) * 4 + 32'($urandom_range(0, 3));
            a1 = 32'($urandom_range(0, 16)) * 4 + 32'($urandom_range(0, 3));
            d0 = $urandom();
            d1 = $urandom();
            s  = $urandom_range(0, 3);
            b0 = (s == 0) ? 4'hF : (s == 1) ? 4'h0 : 4'($urandom_range(0, 15));
            s  = $urandom_range(0, 3);
            b1 = (s == 0) ? 4'hF : (s == 1) ? 4'h0 : 4'($urandom_range(0, 15));
            drive(r, v0, w0, a0, d0, b0, v1, w1, a1, d1, b1);
        end
        idle(4);

        @(negedge clk);
        #1;
        for (int q = 0; q < 4; q++)
            chk($sformatf("queue %0d drained", q), 32'(exp_q[q].size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
